// File: rtl/execute_stage_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, shift types,
// forwarding selects and NZCV bit positions.
package execute_stage_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Select 11 is unused upstream and falls back to the register value.
    function automatic logic [31:0] forwardSelect(
        input logic [1:0]  sel,
        input logic [31:0] regValue,
        input logic [31:0] memValue,
        input logic [31:0] wbValue
    );
        case (sel)
            FWD_MEM: return memValue;
            FWD_WB:  return wbValue;
            default: return regValue;
        endcase
    endfunction

endpackage

// File: rtl/execute_stage_val2_generator.sv
// Second-operand generator: memory offset, rotated immediate, or
// immediate-shifted register.
module val2_generator
    import execute_stage_pkg::*;
(
    input  logic        i_memRead,
    input  logic        i_memWrite,
    input  logic        i_imm,
    input  logic [11:0] i_shiftOperand,
    input  logic [31:0] i_rm,
    output logic [31:0] o_val2
);

    logic [4:0]  w_rotAmount;
    logic [4:0]  w_shiftAmount;
    logic [31:0] w_immByte;
    logic [63:0] w_immRotWide;
    logic [63:0] w_rmRotWide;
    logic [31:0] w_shifted;

    assign w_rotAmount   = {i_shiftOperand[11:8], 1'b0};
    assign w_shiftAmount = i_shiftOperand[11:7];
    assign w_immByte     = {24'd0, i_shiftOperand[7:0]};

    // Rotates are done by shifting a doubled copy; the low half is the result.
    assign w_immRotWide = {w_immByte, w_immByte} >> w_rotAmount;
    assign w_rmRotWide  = {i_rm, i_rm} >> w_shiftAmount;

    always_comb begin
        w_shifted = i_rm;
        case (i_shiftOperand[6:5])
            SHIFT_LSL: w_shifted = i_rm << w_shiftAmount;
            SHIFT_LSR: w_shifted = i_rm >> w_shiftAmount;
            SHIFT_ASR: w_shifted = $signed(i_rm) >>> w_shiftAmount;
            SHIFT_ROR: w_shifted = w_rmRotWide[31:0];
            default:   w_shifted = i_rm;
        endcase
    end

    always_comb begin
        o_val2 = i_rm;
        if (i_memRead || i_memWrite) begin
            o_val2 = {20'd0, i_shiftOperand};
        end else if (i_imm) begin
            o_val2 = w_immRotWide[31:0];
        end else if (!i_shiftOperand[4]) begin
            o_val2 = w_shifted;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, val2 generation, ALU with NZCV flags,
// branch target, and the architectural status register.
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_hold,
    input  logic        i_s,
    input  logic        i_b,
    input  logic        i_memoryReadEnabled,
    input  logic        i_memoryWriteEnabled,
    input  logic [3:0]  i_executionCommand,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_valRn,
    input  logic [31:0] i_valRm,
    input  logic        i_imm,
    input  logic [11:0] i_shiftOperand,
    input  logic [23:0] i_imm24,
    input  logic [3:0]  i_status,
    input  logic [1:0]  i_fwdSelRn,
    input  logic [1:0]  i_fwdSelRm,
    input  logic [31:0] i_memForwardValue,
    input  logic [31:0] i_wbForwardValue,
    output logic [31:0] o_aluResult,
    output logic [31:0] o_storeValue,
    output logic        o_branchTaken,
    output logic [31:0] o_branchAddress,
    output logic [3:0]  o_statusOut
);

    logic [3:0]  r_status;
    logic [31:0] w_rn;
    logic [31:0] w_rm;
    logic [31:0] w_val2;
    logic [31:0] w_op2;
    logic        w_carryIn;
    logic        w_isArith;
    logic [32:0] w_sum;
    logic [31:0] w_result;
    logic        w_flagC;
    logic        w_flagV;
    logic [3:0]  w_nzcv;
    logic        w_unusedStatus;

    assign w_unusedStatus = ^i_status[FLAG_N:FLAG_Z];

    assign w_rn = forwardSelect(i_fwdSelRn, i_valRn, i_memForwardValue, i_wbForwardValue);
    assign w_rm = forwardSelect(i_fwdSelRm, i_valRm, i_memForwardValue, i_wbForwardValue);

    val2_generator u_val2 (
        .i_memRead      (i_memoryReadEnabled),
        .i_memWrite     (i_memoryWriteEnabled),
        .i_imm          (i_imm),
        .i_shiftOperand (i_shiftOperand),
        .i_rm           (w_rm),
        .o_val2         (w_val2)
    );

    // Subtraction is A + ~B + carry so one adder yields both carry and not-borrow.
    always_comb begin
        w_isArith = 1'b0;
        w_op2     = w_val2;
        w_carryIn = 1'b0;
        w_result  = 32'd0;
        case (i_executionCommand)
            CMD_MOV: w_result = w_val2;
            CMD_MVN: w_result = ~w_val2;
            CMD_ADD: w_isArith = 1'b1;
            CMD_ADC: begin
                w_isArith = 1'b1;
                w_carryIn = i_status[FLAG_C];
            end
            CMD_SUB: begin
                w_isArith = 1'b1;
                w_op2     = ~w_val2;
                w_carryIn = 1'b1;
            end
            CMD_SBC: begin
                w_isArith = 1'b1;
                w_op2     = ~w_val2;
                w_carryIn = i_status[FLAG_C];
            end
            CMD_AND: w_result = w_rn & w_val2;
            CMD_ORR: w_result = w_rn | w_val2;
            CMD_EOR: w_result = w_rn ^ w_val2;
            default: w_result = 32'd0;
        endcase
        w_sum = {1'b0, w_rn} + {1'b0, w_op2} + {32'd0, w_carryIn};
        if (w_isArith) begin
            w_result = w_sum[31:0];
        end
    end

    assign w_flagC = w_isArith ? w_sum[32] : i_status[FLAG_C];
    assign w_flagV = w_isArith ? ((w_rn[31] == w_op2[31]) && (w_sum[31] != w_rn[31]))
                               : i_status[FLAG_V];
    assign w_nzcv  = {w_result[31], (w_result == 32'd0), w_flagC, w_flagV};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_status <= 4'b0000;
        end else if (i_s && !i_hold) begin
            r_status <= w_nzcv;
        end
    end

    assign o_aluResult     = w_result;
    assign o_storeValue    = w_rm;
    assign o_branchTaken   = i_b;
    assign o_branchAddress = i_pc + {{6{i_imm24[23]}}, i_imm24, 2'b00};
    assign o_statusOut     = r_status;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage with hand-computed vectors.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        s;
    logic        b;
    logic        memRead;
    logic        memWrite;
    logic [3:0]  cmd;
    logic [31:0] pc;
    logic [31:0] valRn;
    logic [31:0] valRm;
    logic        imm;
    logic [11:0] shiftOperand;
    logic [23:0] imm24;
    logic [3:0]  status;
    logic [1:0]  fwdSelRn;
    logic [1:0]  fwdSelRm;
    logic [31:0] memFwd;
    logic [31:0] wbFwd;
    logic [31:0] aluResult;
    logic [31:0] storeValue;
    logic        branchTaken;
    logic [31:0] branchAddress;
    logic [3:0]  statusOut;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    execute_stage dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_hold               (hold),
        .i_s                  (s),
        .i_b                  (b),
        .i_memoryReadEnabled  (memRead),
        .i_memoryWriteEnabled (memWrite),
        .i_executionCommand   (cmd),
        .i_pc                 (pc),
        .i_valRn              (valRn),
        .i_valRm              (valRm),
        .i_imm                (imm),
        .i_shiftOperand       (shiftOperand),
        .i_imm24              (imm24),
        .i_status             (status),
        .i_fwdSelRn           (fwdSelRn),
        .i_fwdSelRm           (fwdSelRm),
        .i_memForwardValue    (memFwd),
        .i_wbForwardValue     (wbFwd),
        .o_aluResult          (aluResult),
        .o_storeValue         (storeValue),
        .o_branchTaken        (branchTaken),
        .o_branchAddress      (branchAddress),
        .o_statusOut          (statusOut)
    );

    task automatic setIdle();
        rst = 0; hold = 0; s = 0; b = 0; memRead = 0; memWrite = 0;
        cmd = 4'b0000; pc = 32'd0; valRn = 32'd0; valRm = 32'd0; imm = 0;
        shiftOperand = 12'd0; imm24 = 24'd0; status = 4'd0;
        fwdSelRn = 2'b00; fwdSelRm = 2'b00; memFwd = 32'd0; wbFwd = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAlu(input string name, input logic [31:0] expected);
        #1;
        vectors++;
        if (aluResult !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: aluResult got %h expected %h", name, aluResult, expected);
        end
    endtask

    task automatic checkStatus(input string name, input logic [3:0] expected);
        vectors++;
        if (statusOut !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: statusOut got %b expected %b", name, statusOut, expected);
        end
    endtask

    task automatic test_reset();
        setIdle();
        pc = 32'h40;
        rst = 1;
        tick();
        rst = 0;
        checkStatus("reset_status", 4'b0000);
        checkAlu("reset_alu", 32'd0);
        vectors++;
        if (branchTaken !== 1'b0 || branchAddress !== 32'h40) begin
            miscompares++;
            $display("[TB] FAIL reset_branch: got %b/%h expected 0/00000040", branchTaken, branchAddress);
        end
    endtask

    task automatic test_add_overflow();
        setIdle();
        cmd = 4'b0010; valRn = 32'h7FFFFFFF; imm = 1; shiftOperand = 12'h001; s = 1;
        checkAlu("add_ovf_result", 32'h80000000);
        tick();
        s = 0;
        checkStatus("add_ovf_flags", 4'b1001);
    endtask

    task automatic test_sub_sbc();
        setIdle();
        cmd = 4'b0100; valRn = 32'd5; imm = 1; shiftOperand = 12'h005; s = 1;
        checkAlu("sub_result", 32'd0);
        tick();
        checkStatus("sub_flags", 4'b0110);
        cmd = 4'b0101; valRn = 32'd0; shiftOperand = 12'h000; status = 4'b0000;
        checkAlu("sbc_result", 32'hFFFFFFFF);
        tick();
        checkStatus("sbc_flags", 4'b1000);
        cmd = 4'b0011; valRn = 32'hFFFFFFFF; status = 4'b0010;
        checkAlu("adc_result", 32'd0);
        tick();
        s = 0;
        checkStatus("adc_flags", 4'b0110);
    endtask

    task automatic test_val2();
        setIdle();
        cmd = 4'b0001; imm = 1; shiftOperand = 12'h4FF;
        checkAlu("imm_rotate", 32'hFF000000);
        imm = 0; valRm = 32'h80000000; shiftOperand = 12'h240;
        checkAlu("asr4", 32'hF8000000);
        valRm = 32'h80000001;
        shiftOperand = 12'h080; checkAlu("lsl1", 32'h00000002);
        shiftOperand = 12'h220; checkAlu("lsr4", 32'h08000000);
        shiftOperand = 12'h460; checkAlu("ror8", 32'h01800000);
        shiftOperand = 12'h040; checkAlu("asr0_unchanged", 32'h80000001);
        shiftOperand = 12'h091; checkAlu("reg_shift_passthru", 32'h80000001);
        cmd = 4'b0010; memRead = 1; valRn = 32'h1000; shiftOperand = 12'hFFF;
        checkAlu("mem_read_offset", 32'h00001FFF);
        memRead = 0; memWrite = 1; imm = 1; valRn = 32'd0; shiftOperand = 12'h4FF;
        checkAlu("mem_write_offset", 32'h000004FF);
    endtask

    task automatic test_logic_ops();
        setIdle();
        valRn = 32'hFF00FF00; valRm = 32'h0FF00FF0; status = 4'b0011;
        cmd = 4'b0110; checkAlu("and", 32'h0F000F00);
        cmd = 4'b0111; checkAlu("orr", 32'hFFF0FFF0);
        cmd = 4'b1000; checkAlu("eor", 32'hF0F0F0F0);
        valRm = 32'd0;
        cmd = 4'b1001; checkAlu("mvn", 32'hFFFFFFFF);
        valRm = 32'h12345678;
        cmd = 4'b1111; s = 1;
        checkAlu("undefined_op", 32'd0);
        tick();
        s = 0;
        checkStatus("undefined_flags", 4'b0111);
    endtask

    task automatic test_forwarding();
        setIdle();
        cmd = 4'b0010; valRn = 32'd100; valRm = 32'd200;
        fwdSelRn = 2'b01; memFwd = 32'd10; fwdSelRm = 2'b10; wbFwd = 32'd3;
        checkAlu("fwd_add", 32'd13);
        vectors++;
        if (storeValue !== 32'd3) begin
            miscompares++;
            $display("[TB] FAIL fwd_store: got %h expected 00000003", storeValue);
        end
        fwdSelRn = 2'b11; fwdSelRm = 2'b11;
        checkAlu("fwd_sel11_add", 32'd300);
        vectors++;
        if (storeValue !== 32'd200) begin
            miscompares++;
            $display("[TB] FAIL fwd_sel11_store: got %h expected 000000c8", storeValue);
        end
    endtask

    task automatic test_branch();
        setIdle();
        pc = 32'h100; imm24 = 24'hFFFFFE; b = 1;
        #1;
        vectors++;
        if (branchAddress !== 32'hF8 || branchTaken !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL branch_back: got %h/%b expected 000000f8/1", branchAddress, branchTaken);
        end
        pc = 32'hFFFFFFFC; imm24 = 24'h000001; b = 0;
        #1;
        vectors++;
        if (branchAddress !== 32'h0 || branchTaken !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL branch_wrap: got %h/%b expected 00000000/0", branchAddress, branchTaken);
        end
    endtask

    task automatic test_hold_reset();
        setIdle();
        cmd = 4'b1001; s = 1;
        tick();
        checkStatus("hold_setup", 4'b1000);
        cmd = 4'b0001; hold = 1;
        tick();
        checkStatus("hold_blocks", 4'b1000);
        hold = 0; rst = 1;
        tick();
        rst = 0;
        checkStatus("reset_wins", 4'b0000);
        s = 0; cmd = 4'b0010; valRn = 32'h7FFFFFFF; imm = 1; shiftOperand = 12'h001;
        tick();
        checkStatus("s0_retains", 4'b0000);
    endtask

    initial begin
        setIdle();
        #2;
        test_reset();
        test_add_overflow();
        test_sub_sbc();
        test_val2();
        test_logic_ops();
        test_forwarding();
        test_branch();
        test_hold_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage ARM pipeline. Consumes the ID/EX register outputs, applies operand forwarding, generates the second operand (immediate rotate, register shift, or memory offset), runs the ALU and computes the branch target. Owns the architectural NZCV status register. That register is updated on S-suffixed instructions and fed back to decode for condition evaluation. Results go to the EX/MEM stage register and to the fetch stage (branch).

## Interface
Parameters:
- none; widths fixed at 32-bit data, 4-bit command/status.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  pipeline freeze; blocks status-register update.
- s  in  1  update-flags bit from ID/EX.
- b  in  1  branch instruction from ID/EX.
- memoryReadEnabled, memoryWriteEnabled  in  1 each  memory-op flags from ID/EX.
- executionCommand  in  4  ALU opcode.
- pc  in  32  PC+4 of the instruction.
- valRn, valRm  in  32  register-file operands.
- imm  in  1  immediate-operand bit (I).
- shiftOperand  in  12  instruction bits [11:0].
- imm24  in  24  branch offset.
- status  in  4  NZCV snapshot captured at decode; its C is the carry-in.
- fwdSelRn, fwdSelRm  in  2 each  forwarding selects.
- memForwardValue, wbForwardValue  in  32 each  forwarded results.
- aluResult  out  32  ALU result or memory address.
- storeValue  out  32  forwarded Rm, used as STR data.
- branchTaken  out  1  equals b.
- branchAddress  out  32  branch target.
- statusOut  out  4  NZCV register contents, ordered {N,Z,C,V}.

## Operation
- Forwarding for each operand, by select: 00 register value, 01 memForwardValue, 10 wbForwardValue, 11 register value.
- val2 generation, first matching rule wins:
  - Memory op (read or write): val2 = zero-extended shiftOperand[11:0].
  - imm=1: val2 = {24'b0, shiftOperand[7:0]} rotated right by 2*shiftOperand[11:8].
  - imm=0, shiftOperand[4]=0: shift forwarded Rm by shiftOperand[11:7], type shiftOperand[6:5]:
    - 00 LSL, 01 LSR, 10 ASR, 11 ROR.
    - Amount 0 gives Rm unchanged for all four types.
  - imm=0, shiftOperand[4]=1 (register-shifted; not supported): val2 = forwarded Rm.
- ALU, with A = forwarded Rn, B = val2, Cin = status[1]:
  - 0001 MOV B; 1001 MVN ~B; 0010 ADD A+B; 0011 ADC A+B+Cin; 0100 SUB A-B; 0101 SBC A-B-!Cin; 0110 AND; 0111 ORR; 1000 EOR.
  - Any other code: result 0.
- Flags:
  - N = result[31]; Z = (result == 0).
  - Add ops: C = carry-out of bit 31. Sub ops: C = NOT borrow.
  - V = signed overflow of the 33-bit sum/difference.
  - Logical, MOV/MVN and undefined codes: C and V are copied from the status input.
- branchAddress = pc + (sign-extended imm24 << 2), with 32-bit wrap-around.
- Status register (4-bit, the only state in the block):
  - rst: loads 0000.
  - Otherwise, s=1 and hold=0: loads the computed NZCV.
  - Otherwise: holds its value.

## Timing
- Datapath is combinational: aluResult, storeValue, branchAddress and branchTaken are valid in the same cycle as their inputs.
- statusOut changes one cycle after the edge that samples s=1.
- Reset values: statusOut = 0000. All other outputs follow their inputs; after reset the ID/EX register drives zeros, so aluResult = 0, branchTaken = 0 and branchAddress = pc.
- Simultaneous events:
  - rst and s asserted together: rst wins.
  - hold and s asserted together: no update; the value is retained until s is seen with hold low.
- Flush is handled upstream: a flushed ID/EX register delivers s=0, so a flushed instruction never writes flags.
- Reset asserted mid-stream clears the status on that edge; the following instruction sees 0000.

## Structure
- Shared package holds:
  - the executionCommand opcode constants;
  - the shift-type constants;
  - the forwarding-select encodings;
  - the NZCV bit positions (N=3, Z=2, C=1, V=0).
- One sub-module, `val2_generator`, is combinational and contains the rotate, shift and memory-offset logic.
- The ALU stays inline with the flag logic and the status register.

## Test plan
- ADD 0x7FFFFFFF + 1 with s=1 -> aluResult 0x80000000; next cycle statusOut 1001 (N, V set).
- SUB 5-5 with s=1, then SBC 0-0 with status C=0 -> first gives Z=1, C=1 (statusOut 0110); SBC gives 0xFFFFFFFF with N=1, C=0.
- imm=1, shiftOperand 0x4FF, MOV -> val2 0xFF000000; Rm=0x80000000 with ASR #4 (0x240) -> 0xF8000000.
- Forwarding: fwdSelRn=01 with memForwardValue 10; fwdSelRm=10 with wbForwardValue 3; ADD -> 13; storeValue = 3.
- Branch: pc 0x100, imm24 0xFFFFFE -> branchAddress 0xF8; branchTaken follows b.
- s=1 with hold=1, then rst together with s=1 -> status unchanged, then 0000.
